small_tensor_core: RTL and testbench
====================================

SMALL_TENSOR_CORE -- requirements
Module: small_tensor_core

Interface
REQ-001 Parameter DIM, default 4, matrix dimension (rows = columns); only 4 is required to be supported.
REQ-002 Parameter DATA_WIDTH, default 8, element width in bits, two's-complement signed.
REQ-003 clock_in  input  1  single clock; all state changes on its rising edge.
REQ-004 reset_in  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 tensor_core_register_file_write_enable  input  1  high = operand storage is being written this cycle; (re)starts a calculation.
REQ-006 tensor_core_input1  input  signed [DATA_WIDTH] x [DIM][DIM]  matrix A, element [i][j] = row i, column j.
REQ-007 tensor_core_input2  input  signed [DATA_WIDTH] x [DIM][DIM]  matrix B.
REQ-008 tensor_core_output  output  signed [DATA_WIDTH] x [DIM][DIM]  registered result C = A x B.
REQ-009 is_done_with_calculation  output  1  registered, one-cycle pulse marking a new valid C.

Function
REQ-010 States: IDLE, COMPUTE; a 2-bit step counter k (0..3) is valid in COMPUTE.
REQ-011 Write-enable sampled high in any state: on that edge, state becomes COMPUTE, k becomes 0, all 16 accumulators clear to 0, and tensor_core_output is left unchanged.
REQ-012 COMPUTE with write-enable low: each edge, acc[i][j] += A[i][k]*B[k][j] for all i,j in parallel, reading the live inputs, then k increments.
REQ-013 COMPUTE at k=3 with write-enable low: tensor_core_output[i][j] takes the final acc[i][j] value, is_done_with_calculation is set to 1 for exactly one cycle, and state returns to IDLE.
REQ-014 Latency: done and the new C are visible 4 rising edges after the last edge at which write-enable was sampled high.
REQ-015 Arithmetic: products and sums wrap modulo 2^DATA_WIDTH, so C[i][j] equals the low 8 bits of the exact dot product; no saturation and no flags.
REQ-016 Write-enable high during COMPUTE aborts and restarts per REQ-011; no done pulse is produced for the aborted run.
REQ-017 IDLE with write-enable low: outputs hold and done stays 0; the block never self-restarts.
REQ-018 Input changes without write-enable during COMPUTE are used as read; the block does not latch operands.

Reset
REQ-019 reset_in = 0 asynchronously forces state IDLE, k = 0, all accumulators to 0, tensor_core_output all 0, and is_done_with_calculation = 0.
REQ-020 Reset asserted mid-COMPUTE discards the run; no done pulse follows reset release until a new write-enable.

Structure
REQ-021 A shared package holds DIM, DATA_WIDTH, the element typedef (signed logic [DATA_WIDTH-1:0]), the matrix typedef, and the state enum {IDLE, COMPUTE}.
REQ-022 One sub-module, tensor_core_mac, is instantiated DIM*DIM times; each instance is a single accumulator cell that handles clear, multiply-accumulate, and wrap.
REQ-023 The top level holds only the FSM, the k counter, operand selection (A column k and B row k), and the output and done registers.

Verification
REQ-024 A = identity, B[i][j] = 4*i+j, pulse write-enable for 1 cycle -> done exactly 4 edges later and C = B.
REQ-025 A all 2, B all 3 -> C all 24; done high for exactly one cycle, then 0 while C holds.
REQ-026 A all 127, B all 127 -> C all 4 (64516 mod 256); A all -1, B all 1 -> C all -4.
REQ-027 Start with A all 1, B all 1; at k=2 reassert write-enable with A all 2 -> no done at the original time, done 4 edges after the restart, C all 8.
REQ-028 Pull reset_in low during COMPUTE -> C all 0 and done 0 immediately; after release, no done without a new write-enable.

Source files
------------

// File: rtl/small_tensor_core_pkg.sv
// Shared types and sizing for the small tensor core.
// The core multiplies two DIMxDIM signed matrices over DIM sequential steps.
package small_tensor_core_pkg;

    localparam int DIM        = 4;
    localparam int DATA_WIDTH = 8;

    typedef logic signed [DATA_WIDTH-1:0] elem_t;
    typedef elem_t [DIM-1:0][DIM-1:0]     matrix_t;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        COMPUTE = 1'b1
    } state_e;

endpackage

// File: rtl/small_tensor_core_mac.sv
// One accumulator cell of the core: clear, multiply-accumulate, and modular wrap.
// acc_next exposes the value the cell will hold after this edge.
module small_tensor_core_mac
    import small_tensor_core_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    enable,
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic signed [WIDTH-1:0] acc_next
);

    logic signed [WIDTH-1:0] acc_q;
    logic signed [WIDTH-1:0] acc_d;

    // Sum and product stay at WIDTH bits, so overflow simply wraps.
    always_comb begin
        acc_d = acc_q;
        if (clear) begin
            acc_d = '0;
        end else if (enable) begin
            acc_d = acc_q + a * b;
        end
    end

    assign acc_next = acc_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/small_tensor_core.sv
// Sequential DIMxDIM matrix multiplier: one rank-1 update per cycle over DIM steps.
// Operands are read live every step; only the result and done pulse are registered.
module small_tensor_core
    import small_tensor_core_pkg::*;
#(
    parameter int DIM        = small_tensor_core_pkg::DIM,
    parameter int DATA_WIDTH = small_tensor_core_pkg::DATA_WIDTH
) (
    input  logic                                 clock_in,
    input  logic                                 reset_in,
    input  logic                                 tensor_core_register_file_write_enable,
    input  logic [DIM*DIM*DATA_WIDTH-1:0]        tensor_core_input1,
    input  logic [DIM*DIM*DATA_WIDTH-1:0]        tensor_core_input2,
    output logic [DIM*DIM*DATA_WIDTH-1:0]        tensor_core_output,
    output logic                                 is_done_with_calculation
);

    localparam int K_W = (DIM > 1) ? $clog2(DIM) : 1;
    localparam int MW  = DIM * DIM * DATA_WIDTH;

    state_e                         state_q, state_d;
    logic [K_W-1:0]                 k_q, k_d;
    logic [MW-1:0]                  out_q, out_d;
    logic                           done_q, done_d;
    logic                           mac_clear;
    logic                           mac_enable;

    logic signed [DATA_WIDTH-1:0]   a_col [DIM];
    logic signed [DATA_WIDTH-1:0]   b_row [DIM];
    logic [MW-1:0]                  acc_next_flat;

    // Column k of A and row k of B; element [i][j] sits at flat index i*DIM+j.
    always_comb begin
        for (int i = 0; i < DIM; i++) begin
            a_col[i] = tensor_core_input1[(i*DIM + int'(k_q))*DATA_WIDTH +: DATA_WIDTH];
            b_row[i] = tensor_core_input2[(int'(k_q)*DIM + i)*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    generate
        for (genvar gi = 0; gi < DIM; gi++) begin : g_row
            for (genvar gj = 0; gj < DIM; gj++) begin : g_col
                logic signed [DATA_WIDTH-1:0] cell_next;

                small_tensor_core_mac #(
                    .WIDTH (DATA_WIDTH)
                ) u_mac (
                    .clk      (clock_in),
                    .rst_n    (reset_in),
                    .clear    (mac_clear),
                    .enable   (mac_enable),
                    .a        (a_col[gi]),
                    .b        (b_row[gj]),
                    .acc_next (cell_next)
                );

                assign acc_next_flat[(gi*DIM + gj)*DATA_WIDTH +: DATA_WIDTH] = cell_next;
            end
        end
    endgenerate

    // A write always wins, so it both starts and aborts a run.
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        out_d      = out_q;
        done_d     = 1'b0;
        mac_clear  = 1'b0;
        mac_enable = 1'b0;
        if (tensor_core_register_file_write_enable) begin
            state_d   = COMPUTE;
            k_d       = '0;
            mac_clear = 1'b1;
        end else if (state_q == COMPUTE) begin
            mac_enable = 1'b1;
            k_d        = k_q + 1'b1;
            if (k_q == K_W'(DIM - 1)) begin
                out_d   = acc_next_flat;
                done_d  = 1'b1;
                state_d = IDLE;
                k_d     = '0;
            end
        end
    end

    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
            state_q <= IDLE;
            k_q     <= '0;
            out_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            out_q   <= out_d;
            done_q  <= done_d;
        end
    end

    assign tensor_core_output       = out_q;
    assign is_done_with_calculation = done_q;

endmodule

// File: tb/tb_small_tensor_core.sv
// Directed bench for small_tensor_core: latency, wrap, restart and reset behaviour.
module tb_small_tensor_core;

    localparam int DIM = 4;
    localparam int DW  = 8;
    localparam int MW  = DIM * DIM * DW;

    logic          clk;
    logic          rst_n;
    logic          we;
    logic [MW-1:0] in1;
    logic [MW-1:0] in2;
    logic [MW-1:0] c_out;
    logic          done;

    int checks;
    int failures;

    small_tensor_core #(
        .DIM        (DIM),
        .DATA_WIDTH (DW)
    ) dut (
        .clock_in                               (clk),
        .reset_in                               (rst_n),
        .tensor_core_register_file_write_enable (we),
        .tensor_core_input1                     (in1),
        .tensor_core_input2                     (in2),
        .tensor_core_output                     (c_out),
        .is_done_with_calculation               (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [MW-1:0] fill(input logic [DW-1:0] v);
        logic [MW-1:0] r;
        for (int e = 0; e < DIM*DIM; e++) r[e*DW +: DW] = v;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_we();
        we = 1'b1;
        step();
        we = 1'b0;
    endtask

    // Three quiet edges, then done and C on the fourth, then done drops while C holds.
    task automatic run_and_check(input string name, input logic [MW-1:0] exp_c);
        for (int s = 1; s <= 3; s++) begin
            step();
            checks++;
            if (done !== 1'b0) begin
                failures++;
                $display("FAIL %s early_done edge=%0d got=%b want=0", name, s, done);
            end
        end
        step();
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL %s done_edge4 got=%b want=1", name, done);
        end
        checks++;
        if (c_out !== exp_c) begin
            failures++;
            $display("FAIL %s result got=%h want=%h", name, c_out, exp_c);
        end
        step();
        checks++;
        if (done !== 1'b0 || c_out !== exp_c) begin
            failures++;
            $display("FAIL %s hold done=%b c=%h want done=0 c=%h", name, done, c_out, exp_c);
        end
        $display("txn %s c=%h", name, c_out);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        we    = 1'b0;
        in1   = '0;
        in2   = '0;
        #12;
        checks++;
        if (c_out !== '0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_state c=%h done=%b want c=0 done=0", c_out, done);
        end
        rst_n = 1'b1;
        step();
        step();
        checks++;
        if (done !== 1'b0 || c_out !== '0) begin
            failures++;
            $display("FAIL idle_after_reset c=%h done=%b want c=0 done=0", c_out, done);
        end
        $display("txn reset c=%h done=%b", c_out, done);
    endtask

    task automatic test_identity();
        logic [MW-1:0] exp_c;
        for (int i = 0; i < DIM; i++) begin
            for (int j = 0; j < DIM; j++) begin
                in1[(i*DIM+j)*DW +: DW] = (i == j) ? 8'd1 : 8'd0;
                in2[(i*DIM+j)*DW +: DW] = 8'(4*i + j);
                exp_c[(i*DIM+j)*DW +: DW] = 8'(4*i + j);
            end
        end
        pulse_we();
        run_and_check("identity", exp_c);
    endtask

    task automatic test_twos_threes();
        in1 = fill(8'd2);
        in2 = fill(8'd3);
        pulse_we();
        run_and_check("twos_threes", fill(8'd24));
        for (int s = 0; s < 3; s++) step();
        checks++;
        if (done !== 1'b0 || c_out !== fill(8'd24)) begin
            failures++;
            $display("FAIL idle_hold done=%b c=%h want done=0 c=%h", done, c_out, fill(8'd24));
        end
    endtask

    task automatic test_wrap();
        in1 = fill(8'd127);
        in2 = fill(8'd127);
        pulse_we();
        run_and_check("wrap_127", fill(8'd4));
        in1 = fill(8'hFF);
        in2 = fill(8'd1);
        pulse_we();
        run_and_check("wrap_neg1", fill(8'hFC));
    endtask

    task automatic test_restart();
        in1 = fill(8'd1);
        in2 = fill(8'd1);
        pulse_we();
        step();
        step();
        in1 = fill(8'd2);
        pulse_we();
        run_and_check("restart", fill(8'd8));
    endtask

    task automatic test_reset_mid();
        in1 = fill(8'd5);
        in2 = fill(8'd7);
        pulse_we();
        step();
        step();
        rst_n = 1'b0;
        #2;
        checks++;
        if (c_out !== '0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid c=%h done=%b want c=0 done=0", c_out, done);
        end
        step();
        rst_n = 1'b1;
        for (int s = 1; s <= 6; s++) begin
            step();
            checks++;
            if (done !== 1'b0 || c_out !== '0) begin
                failures++;
                $display("FAIL post_reset_quiet edge=%0d done=%b c=%h want done=0 c=0", s, done, c_out);
            end
        end
        $display("txn reset_mid c=%h done=%b", c_out, done);
        pulse_we();
        run_and_check("after_reset", fill(8'd140));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_identity();
        test_twos_threes();
        test_wrap();
        test_restart();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
